// File: rtl/ifetch_mem_resp.sv
// Instruction-fetch responder: valid/ready fetch requests served from an internal
// synchronous-read RAM, in-order responses through a read stage plus 2-entry FIFO.
module ifetch_mem_resp #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter int                  DEPTH_WORDS = 1024,
    parameter logic [PC_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                  AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_req_valid_i,
    output logic                   if_req_ready_o,
    input  logic [PC_WIDTH-1:0]    if_req_pc_i,
    output logic                   if_resp_valid_o,
    input  logic                   if_resp_ready_i,
    output logic                   if_resp_err_o,
    output logic [INSTR_WIDTH-1:0] if_resp_instr_o,
    input  logic                   ld_we_i,
    input  logic [AW-1:0]          ld_addr_i,
    input  logic [INSTR_WIDTH-1:0] ld_data_i
);

    logic [INSTR_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [INSTR_WIDTH-1:0] rdata_q;

    logic                   infl_valid_q, infl_valid_d;
    logic                   infl_err_q, infl_err_d;
    logic [INSTR_WIDTH-1:0] fifo_data_q [2];
    logic [1:0]             fifo_err_q;
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             cnt_q, cnt_d;

    logic [PC_WIDTH-1:0]    offset;
    logic [AW-1:0]          rd_idx;
    logic                   fault, accept, rd_en;
    logic [1:0]             occ;
    logic                   resp_valid, fifo_empty, pop, pop_fifo, pop_infl, push;
    logic [INSTR_WIDTH-1:0] infl_instr, head_instr;
    logic                   head_err;

    // BASE_ADDR is word aligned, so the low offset bits equal the low pc bits.
    assign offset = if_req_pc_i - BASE_ADDR;
    assign rd_idx = offset[AW+1:2];
    assign fault  = (|offset[1:0]) || (if_req_pc_i < BASE_ADDR) || (|offset[PC_WIDTH-1:AW+2]);

    assign occ            = cnt_q + {1'b0, infl_valid_q};
    assign if_req_ready_o = (occ < 2'd2);
    assign accept         = if_req_valid_i && if_req_ready_o;
    assign rd_en          = accept && !fault;

    assign resp_valid = (occ != 2'd0);
    assign fifo_empty = (cnt_q == 2'd0);
    assign pop        = resp_valid && if_resp_ready_i;
    assign pop_fifo   = pop && !fifo_empty;
    // With an empty FIFO the read stage is the head and may be consumed directly.
    assign pop_infl   = pop && fifo_empty;
    assign push       = infl_valid_q && !pop_infl;

    assign infl_instr = infl_err_q ? '0 : rdata_q;
    assign head_err   = fifo_empty ? infl_err_q : fifo_err_q[rd_ptr_q];
    assign head_instr = fifo_empty ? infl_instr : fifo_data_q[rd_ptr_q];

    assign if_resp_valid_o = resp_valid;
    assign if_resp_err_o   = resp_valid && head_err;
    assign if_resp_instr_o = resp_valid ? head_instr : '0;

    always_comb begin
        infl_valid_d = accept;
        infl_err_d   = accept && fault;
        cnt_d        = cnt_q + {1'b0, push} - {1'b0, pop_fifo};
    end

    // Read-first RAM: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ld_we_i) begin
            mem[ld_addr_i] <= ld_data_i;
        end
        if (rd_en) begin
            rdata_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_valid_q <= 1'b0;
            infl_err_q   <= 1'b0;
            fifo_err_q   <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
            end
        end else begin
            infl_valid_q <= infl_valid_d;
            infl_err_q   <= infl_err_d;
            cnt_q        <= cnt_d;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= infl_instr;
                fifo_err_q[wr_ptr_q]  <= infl_err_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop_fifo) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_mem_resp.sv
// Scoreboard bench for ifetch_mem_resp: expected responses queued on accept and
// compared in order as the DUT returns them.
module tb_ifetch_mem_resp;

    localparam logic [32:0] BAD = 33'h1_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid_i = 1'b0;
    logic        if_req_ready_o;
    logic [31:0] if_req_pc_i = '0;
    logic        if_resp_valid_o;
    logic        if_resp_ready_i = 1'b0;
    logic        if_resp_err_o;
    logic [31:0] if_resp_instr_o;
    logic        ld_we_i = 1'b0;
    logic [9:0]  ld_addr_i = '0;
    logic [31:0] ld_data_i = '0;

    int asserts = 0;
    int fails   = 0;

    logic [31:0] shadow [1024];
    logic [32:0] exp_q [$];
    logic [32:0] chk_obs_q [$];
    logic [32:0] chk_exp_q [$];

    logic        last_acc, last_pop, obs_ready, obs_valid, obs_err;
    logic [31:0] obs_instr;
    int          pre_occ;

    ifetch_mem_resp dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_req_valid_i  (if_req_valid_i),
        .if_req_ready_o  (if_req_ready_o),
        .if_req_pc_i     (if_req_pc_i),
        .if_resp_valid_o (if_resp_valid_o),
        .if_resp_ready_i (if_resp_ready_i),
        .if_resp_err_o   (if_resp_err_o),
        .if_resp_instr_o (if_resp_instr_o),
        .ld_we_i         (ld_we_i),
        .ld_addr_i       (ld_addr_i),
        .ld_data_i       (ld_data_i)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] expected(input logic [31:0] pc);
        logic [31:0] off;
        if (pc[1:0] != 2'b00 || pc < 32'h8000_0000 || pc >= 32'h8000_1000) begin
            return {1'b1, 32'h0};
        end
        off = (pc - 32'h8000_0000) >> 2;
        return {1'b0, shadow[off[9:0]]};
    endfunction

    // One clock: drive at the falling edge, observe, then let the rising edge happen.
    task automatic tick(input logic rv, input logic [31:0] pc, input logic rr,
                        input logic we, input logic [9:0] la, input logic [31:0] ld);
        if_req_valid_i  = rv;
        if_req_pc_i     = pc;
        if_resp_ready_i = rr;
        ld_we_i         = we;
        ld_addr_i       = la;
        ld_data_i       = ld;
        #1;
        obs_ready = if_req_ready_o;
        obs_valid = if_resp_valid_o;
        obs_err   = if_resp_err_o;
        obs_instr = if_resp_instr_o;
        pre_occ   = exp_q.size();
        last_acc  = rv && obs_ready;
        last_pop  = obs_valid && rr;
        if (last_pop) begin
            chk_obs_q.push_back({obs_err, obs_instr});
            if (exp_q.size() > 0) chk_exp_q.push_back(exp_q.pop_front());
            else chk_exp_q.push_back(BAD);
        end
        if (last_acc) exp_q.push_back(expected(pc));
        @(posedge clk);
        if (we) shadow[la] = ld;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b1, 1'b0, 10'd0, 32'h0);
    endtask

    task automatic test_reset();
        #2;
        asserts++; if (if_req_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b want=1", if_req_ready_o); end
        asserts++; if (if_resp_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", if_resp_valid_o); end
        asserts++; if (if_resp_err_o !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", if_resp_err_o); end
        asserts++; if (if_resp_instr_o !== 32'h0) begin fails++; $display("FAIL reset_instr got=%h want=0", if_resp_instr_o); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: ready=%b valid=%b", if_req_ready_o, if_resp_valid_o);
    endtask

    task automatic test_preload();
        logic [31:0] words [6];
        words = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0, 32'hAAAA_AAAA};
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b1, 10'(i), words[i]);
            $display("load word %0d = %h", i, words[i]);
        end
    endtask

    task automatic test_stream();
        logic acc_h [6];
        logic pop_h [6];
        logic [32:0] o, e;
        for (int i = 0; i < 6; i++) begin
            tick(i < 4, 32'h8000_0000 + 32'(4 * i), 1'b1, 1'b0, 10'd0, 32'h0);
            acc_h[i] = last_acc;
            pop_h[i] = last_pop;
        end
        for (int i = 0; i < 4; i++) begin
            asserts++; if (acc_h[i] !== 1'b1) begin fails++; $display("FAIL stream_accept%0d got=%b want=1", i, acc_h[i]); end
            asserts++; if (pop_h[i+1] !== 1'b1) begin fails++; $display("FAIL stream_latency%0d got=%b want=1", i, pop_h[i+1]); end
        end
        asserts++; if (pop_h[0] !== 1'b0) begin fails++; $display("FAIL stream_early_resp got=%b want=0", pop_h[0]); end
        while (chk_obs_q.size() > 0) begin
            o = chk_obs_q.pop_front(); e = chk_exp_q.pop_front();
            asserts++;
            if (o !== e) begin fails++; $display("FAIL stream_data got=%h want=%h", o, e); end
            else $display("stream resp err=%b instr=%h", o[32], o[31:0]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic acc_h [6];
        logic [32:0] o, e;
        tick(1'b1, 32'h8000_0000, 1'b0, 1'b0, 10'd0, 32'h0); acc_h[0] = last_acc;
        tick(1'b1, 32'h8000_0004, 1'b0, 1'b0, 10'd0, 32'h0); acc_h[1] = last_acc;
        held = obs_instr;
        asserts++; if (held !== 32'h0000_0013) begin fails++; $display("FAIL bp_head got=%h want=00000013", held); end
        tick(1'b1, 32'h8000_0008, 1'b0, 1'b0, 10'd0, 32'h0); acc_h[2] = last_acc;
        asserts++; if (obs_ready !== 1'b0) begin fails++; $display("FAIL bp_ready got=%b want=0", obs_ready); end
        asserts++; if (obs_valid !== 1'b1 || obs_instr !== held || obs_err !== 1'b0) begin
            fails++; $display("FAIL bp_stable got=%b/%h want=1/%h", obs_valid, obs_instr, held);
        end
        tick(1'b1, 32'h8000_0008, 1'b1, 1'b0, 10'd0, 32'h0); acc_h[3] = last_acc;
        tick(1'b1, 32'h8000_0008, 1'b1, 1'b0, 10'd0, 32'h0); acc_h[4] = last_acc;
        asserts++; if (acc_h[0] !== 1'b1 || acc_h[1] !== 1'b1 || acc_h[2] !== 1'b0) begin
            fails++; $display("FAIL bp_accepts got=%b%b%b want=110", acc_h[0], acc_h[1], acc_h[2]);
        end
        asserts++; if (acc_h[3] !== 1'b0 || acc_h[4] !== 1'b1) begin
            fails++; $display("FAIL bp_third_accept got=%b%b want=01", acc_h[3], acc_h[4]);
        end
        idle(4);
        asserts++; if (chk_obs_q.size() != 3) begin fails++; $display("FAIL bp_count got=%0d want=3", chk_obs_q.size()); end
        while (chk_obs_q.size() > 0) begin
            o = chk_obs_q.pop_front(); e = chk_exp_q.pop_front();
            asserts++;
            if (o !== e) begin fails++; $display("FAIL bp_data got=%h want=%h", o, e); end
            else $display("bp resp err=%b instr=%h", o[32], o[31:0]);
        end
    endtask

    task automatic test_faults();
        logic [31:0] pcs [4];
        logic [32:0] want [4];
        logic [32:0] o, e;
        pcs  = '{32'h8000_0002, 32'h8000_0004, 32'h7FFF_FFFC, 32'h8000_1000};
        want = '{{1'b1, 32'h0}, {1'b0, 32'h0010_0093}, {1'b1, 32'h0}, {1'b1, 32'h0}};
        for (int i = 0; i < 4; i++) tick(1'b1, pcs[i], 1'b1, 1'b0, 10'd0, 32'h0);
        idle(3);
        asserts++; if (chk_obs_q.size() != 4) begin fails++; $display("FAIL fault_count got=%0d want=4", chk_obs_q.size()); end
        for (int i = 0; i < 4 && chk_obs_q.size() > 0; i++) begin
            o = chk_obs_q.pop_front(); e = chk_exp_q.pop_front();
            asserts++;
            if (o !== want[i] || e !== want[i]) begin fails++; $display("FAIL fault_resp%0d got=%h want=%h", i, o, want[i]); end
            else $display("fault pc=%h err=%b instr=%h", pcs[i], o[32], o[31:0]);
        end
    endtask

    task automatic test_collision();
        logic [32:0] o, e;
        tick(1'b1, 32'h8000_0014, 1'b1, 1'b1, 10'd5, 32'h5555_5555);
        tick(1'b1, 32'h8000_0014, 1'b1, 1'b0, 10'd0, 32'h0);
        idle(3);
        asserts++; if (chk_obs_q.size() != 2) begin fails++; $display("FAIL coll_count got=%0d want=2", chk_obs_q.size()); end
        if (chk_obs_q.size() == 2) begin
            asserts++; if (chk_obs_q[0] !== {1'b0, 32'hAAAA_AAAA}) begin fails++; $display("FAIL coll_old got=%h want=0aaaaaaaa", chk_obs_q[0]); end
            asserts++; if (chk_obs_q[1] !== {1'b0, 32'h5555_5555}) begin fails++; $display("FAIL coll_new got=%h want=055555555", chk_obs_q[1]); end
        end
        while (chk_obs_q.size() > 0) begin
            o = chk_obs_q.pop_front(); e = chk_exp_q.pop_front();
            asserts++;
            if (o !== e) begin fails++; $display("FAIL coll_data got=%h want=%h", o, e); end
            else $display("collision resp instr=%h", o[31:0]);
        end
    endtask

    task automatic test_reset_midstream();
        int stale;
        logic [32:0] o, e;
        tick(1'b1, 32'h8000_0000, 1'b0, 1'b0, 10'd0, 32'h0);
        tick(1'b1, 32'h8000_0004, 1'b0, 1'b0, 10'd0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        asserts++; if (if_resp_valid_o !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b want=0", if_resp_valid_o); end
        asserts++; if (if_req_ready_o !== 1'b1) begin fails++; $display("FAIL midrst_ready got=%b want=1", if_req_ready_o); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        stale = chk_obs_q.size();
        asserts++; if (stale != 0) begin fails++; $display("FAIL midrst_stale got=%0d want=0", stale); end
        chk_obs_q.delete(); chk_exp_q.delete();
        tick(1'b1, 32'h8000_0000, 1'b1, 1'b0, 10'd0, 32'h0);
        idle(2);
        asserts++; if (chk_obs_q.size() != 1) begin fails++; $display("FAIL midrst_count got=%0d want=1", chk_obs_q.size()); end
        while (chk_obs_q.size() > 0) begin
            o = chk_obs_q.pop_front(); e = chk_exp_q.pop_front();
            asserts++;
            if (o !== {1'b0, 32'h0000_0013} || e !== o) begin fails++; $display("FAIL midrst_data got=%h want=000000013", o); end
            else $display("post-reset resp instr=%h", o[31:0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] bad_pcs [3];
        logic [31:0] pc;
        logic        we;
        logic [32:0] o, e;
        int          n = 0;
        bad_pcs = '{32'h8000_0001, 32'h0000_1000, 32'hFFFF_FFFC};
        for (int i = 0; i < 16; i++) tick(1'b0, 32'h0, 1'b1, 1'b1, 10'(i), $urandom);
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 9) == 0) pc = bad_pcs[$urandom_range(0, 2)];
            else pc = 32'h8000_0000 + 32'(4 * $urandom_range(0, 15));
            we = ($urandom_range(0, 7) == 0);
            tick($urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) != 0, we,
                 10'($urandom_range(0, 15)), $urandom);
            asserts++;
            if (obs_ready !== (pre_occ < 2) || pre_occ > 2) begin
                fails++; $display("FAIL rand_ready cyc=%0d got=%b occ=%0d", c, obs_ready, pre_occ);
            end
            while (chk_obs_q.size() > 0) begin
                o = chk_obs_q.pop_front(); e = chk_exp_q.pop_front();
                n++;
                asserts++;
                if (o !== e) begin fails++; $display("FAIL rand_resp cyc=%0d got=%h want=%h", c, o, e); end
            end
        end
        idle(4);
        while (chk_obs_q.size() > 0) begin
            o = chk_obs_q.pop_front(); e = chk_exp_q.pop_front();
            n++;
            asserts++;
            if (o !== e) begin fails++; $display("FAIL rand_tail got=%h want=%h", o, e); end
        end
        asserts++; if (exp_q.size() != 0) begin fails++; $display("FAIL rand_lost got=%0d want=0 outstanding", exp_q.size()); end
        $display("random: %0d responses checked", n);
    endtask

    initial begin
        test_reset();
        test_preload();
        test_stream();
        test_backpressure();
        test_faults();
        test_collision();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
